// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg: shared definitions for the sequential ALU.
//   - opcode encodings presented on ula_seq.selecao
//   - FSM state encoding (IDLE / RUN / FIN)
//   - packed flag record {C, Z, N, V} matching the ula_seq.flags port order
// ---------------------------------------------------------------------------
package ula_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Field order gives flags[3]=C, flags[2]=Z, flags[1]=N, flags[0]=V.
    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

endpackage

// File: rtl/ula_mul.sv
// ---------------------------------------------------------------------------
// ula_mul: shift-add multiplier core, one partial product per clock.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, clears all state
//   load  : latch a (multiplicand) and b (multiplier), clear accumulator,
//           arm the step counter with WIDTH
//   a, b  : operands, sampled only when load is high
//   count : remaining iterations; the core steps on every edge while non-zero
//   prod  : 2*WIDTH-bit accumulator, final once count reaches zero
//   last  : high during the cycle whose edge performs the final iteration
// ---------------------------------------------------------------------------
module ula_mul #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [CW-1:0]        count,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 last
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // NOTE: state registers use non-blocking assignments only, so every
    // register in this block samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            count  <= CW'(WIDTH);
        end else if (count != '0) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

    assign last = (count == CW'(1));

endmodule

// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq: clocked SAP ALU with single- and multi-cycle operations.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset; aborts any running operation
//   a, b    : operands (accumulator, B register)
//   selecao : opcode (see ula_pkg OP_*)
//   start   : one-cycle request, honoured only in IDLE
//   alu_out : bus output enable
//   bus     : result register when alu_out is high, else zero
//   busy    : high while a multi-cycle operation (RUN or FIN) is in progress
//   done    : one-cycle pulse after result/flags have been updated
//   flags   : {C, Z, N, V}, written only when an operation completes
// ---------------------------------------------------------------------------
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       selecao,
    input  logic             start,
    input  logic             alu_out,
    output logic [WIDTH-1:0] bus,
    output logic             busy,
    output logic             done,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t state, state_nx;

    logic [WIDTH-1:0] result_q;
    flags_t           flags_q;
    logic             done_q;
    logic [2:0]       op_q;

    // SHR datapath: shifting register, remaining bit count, last bit out.
    logic [WIDTH-1:0] shr_q;
    logic [SHW-1:0]   shr_cnt;
    logic             shr_c;
    logic [SHW-1:0]   shr_amt;

    // Multiplier core handshake.
    logic               mul_load;
    logic [CW-1:0]      mul_count;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_last;

    // Single-cycle ALU, evaluated on the live inputs.
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    // Value presented to the result/flag registers on completion.
    logic             commit;
    logic [WIDTH-1:0] commit_res;
    logic             commit_c, commit_v;

    assign shr_amt = b[SHW-1:0];
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        alu_res = a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (selecao)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                // No carry out of a + ~b + 1 means a borrow (a < b).
                alu_c   = ~sum_sub[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            // MUL never commits here; SHR by 0 returns a with C = 0.
            default: alu_res = a;
        endcase
    end

    // Next-state and completion logic.
    always_comb begin
        state_nx   = state;
        mul_load   = 1'b0;
        commit     = 1'b0;
        commit_res = alu_res;
        commit_c   = alu_c;
        commit_v   = alu_v;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (selecao == OP_MUL) begin
                        mul_load = 1'b1;
                        state_nx = RUN;
                    end else if (selecao == OP_SHR && shr_amt != '0) begin
                        state_nx = RUN;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            RUN: begin
                if (op_q == OP_MUL) begin
                    // An empty counter can only mean the core was never
                    // armed; leave RUN rather than hang.
                    if (mul_last || mul_count == '0) begin
                        state_nx = FIN;
                    end
                end else if (shr_cnt == SHW'(1)) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                commit   = 1'b1;
                commit_v = 1'b0;
                if (op_q == OP_MUL) begin
                    commit_res = mul_prod[WIDTH-1:0];
                    commit_c   = |mul_prod[2*WIDTH-1:WIDTH];
                end else begin
                    commit_res = shr_q;
                    commit_c   = shr_c;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            op_q     <= OP_ADD;
            shr_q    <= '0;
            shr_cnt  <= '0;
            shr_c    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= commit;
            if (commit) begin
                result_q  <= commit_res;
                flags_q.c <= commit_c;
                flags_q.z <= (commit_res == '0);
                flags_q.n <= commit_res[WIDTH-1];
                flags_q.v <= commit_v;
            end
            if (state == IDLE && start) begin
                op_q    <= selecao;
                shr_q   <= a;
                shr_cnt <= shr_amt;
                shr_c   <= 1'b0;
            end else if (state == RUN && op_q == OP_SHR) begin
                shr_c   <= shr_q[0];
                shr_q   <= shr_q >> 1;
                shr_cnt <= shr_cnt - SHW'(1);
            end
        end
    end

    ula_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .load  (mul_load),
        .a     (a),
        .b     (b),
        .count (mul_count),
        .prod  (mul_prod),
        .last  (mul_last)
    );

    assign bus   = alu_out ? result_q : '0;
    assign busy  = (state != IDLE);
    assign done  = done_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_ula_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_seq: directed self-checking bench for ula_seq (WIDTH = 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ula_seq;
    import ula_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       selecao;
    logic             start;
    logic             alu_out;
    logic [WIDTH-1:0] bus;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    int checks = 0;
    int errors = 0;

    ula_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .selecao (selecao),
        .start   (start),
        .alu_out (alu_out),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a single-cycle op and check result, flags and done one edge later.
    task automatic single(input string tag, input logic [2:0] op,
                          input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] exp_res, input logic [3:0] exp_flags);
        selecao = op; a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_res"},   bus,   exp_res);
        check({tag, "_flags"}, flags, exp_flags);
        check({tag, "_done"},  done,  1'b1);
        check({tag, "_busy"},  busy,  1'b0);
    endtask

    // Count busy cycles and the cycle index (1 = first cycle after the
    // start edge) at which done appears; optional ignored restart at cycle 3.
    task automatic run_multi(input bit restart, output int busy_cnt,
                             output int done_at);
        busy_cnt = 0;
        done_at  = 0;
        for (int cyc = 1; cyc <= 20 && done_at == 0; cyc++) begin
            if (busy) busy_cnt++;
            if (done) done_at = cyc;
            if (restart && cyc == 3) begin
                a = 8'hFF; b = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
                if (cyc == 4) begin
                    a = 8'h00; b = 8'h00;
                end
            end
            if (done_at == 0) tick();
        end
    endtask

    int busy_cnt, done_at, done_seen;

    initial begin
        rst = 1'b1; a = '0; b = '0; selecao = OP_ADD; start = 1'b0;
        alu_out = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_bus",   bus,   8'h00);
        check("rst_flags", flags, 4'b0000);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);

        // ADD wrap: C=1 Z=1
        single("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100);
        tick();
        check("add_done_pulse", done, 1'b0);
        // ADD signed overflow: N=1 V=1
        single("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011);
        // SUB with borrow, issued in the done cycle of the previous op
        single("sub_50_70", OP_SUB, 8'h50, 8'h70, 8'hE0, 4'b1010);
        single("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h7F, 8'b0001);
        single("and",       OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        single("or",        OP_OR,  8'h0F, 8'h30, 8'h3F, 4'b0000);
        single("xor_zero",  OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0100);
        tick();

        // MUL 0x10 x 0x11 = 0x0110; restart at cycle 3 must be ignored
        single("pre_mul", OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001);
        selecao = OP_MUL; a = 8'h10; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        check("mul_busy_start", busy, 1'b1);
        check("mul_done_start", done, 1'b0);
        check("mul_hold_res",   bus,  8'h7F);
        run_multi(1'b1, busy_cnt, done_at);
        check("mul_busy_cycles", busy_cnt, 9);
        check("mul_done_cycle",  done_at,  10);
        check("mul_res",   bus,   8'h10);
        check("mul_flags", flags, 4'b1000);
        tick();
        check("mul_done_pulse", done, 1'b0);
        check("mul_idle",       busy, 1'b0);

        // SHR 0x84 >> 3 = 0x10, last bit out = 1
        selecao = OP_SHR; a = 8'h84; b = 8'h03; start = 1'b1;
        tick();
        start = 1'b0;
        run_multi(1'b0, busy_cnt, done_at);
        check("shr_busy_cycles", busy_cnt, 4);
        check("shr_done_cycle",  done_at,  5);
        check("shr_res",   bus,   8'h10);
        check("shr_flags", flags, 4'b1000);
        tick();
        // SHR by b=0x08 -> amount 0 -> single cycle
        single("shr_amt0", OP_SHR, 8'h84, 8'h08, 8'h84, 4'b0010);
        tick();

        // Reset in the middle of a MUL
        selecao = OP_MUL; a = 8'h10; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  busy,  1'b0);
        check("abort_bus",   bus,   8'h00);
        check("abort_flags", flags, 4'b0000);
        check("abort_done",  done,  1'b0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        single("post_abort_add", OP_ADD, 8'h02, 8'h03, 8'h05, 4'b0000);
        tick();

        // NOT with bus enable toggling
        alu_out = 1'b0;
        selecao = OP_NOT; a = 8'h0F; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        check("not_bus_off", bus,   8'h00);
        check("not_flags",   flags, 4'b0010);
        check("not_done",    done,  1'b1);
        alu_out = 1'b1;
        #1;
        check("not_bus_on", bus, 8'hF0);
        alu_out = 1'b0;
        #1;
        check("not_bus_off2", bus, 8'h00);
        alu_out = 1'b1;
        tick();
        check("not_bus_hold", bus,  8'hF0);
        check("not_idle",     busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
